// File: rtl/spi_slave_pkg.sv
// Shared types for the SPI slave command controller: FSM states, direction
// encoding and the debug view exported by the controller.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_WAIT = 3'd1,
    WR_REQ  = 3'd2,
    WR_RESP = 3'd3,
    RD_REQ  = 3'd4,
    RD_RESP = 3'd5,
    RD_PUSH = 3'd6
  } spi_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef struct packed {
    spi_state_e state;
    logic       rd;
    logic       err;
  } spi_dbg_t;

  function automatic int unsigned addr_step(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/spi_slave_addr_cnt.sv
// Loadable word-address counter; increments wrap modulo 2^ADDR_W.
module spi_slave_addr_cnt #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned STEP   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] cnt_o
);

  localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + STEP_W;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/spi_slave_cmd_ctrl.sv
// Turns each synchronized SPI transfer into single-word bus requests with an
// auto-incrementing address, moving RX words to the bus and bus words to TX.
module spi_slave_cmd_ctrl
  import spi_slave_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic                      cs_sync,
  input  logic [AXI_ADDR_WIDTH-1:0] address_sync,
  input  logic                      address_valid_sync,
  input  logic                      rd_wr_sync,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      wr_data_valid,
  output logic                      wr_data_ready,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_data_valid,
  input  logic                      rd_data_ready,
  output logic                      req_valid,
  input  logic                      req_ready,
  output logic                      req_we,
  output logic [AXI_ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic                      resp_valid,
  input  logic [DATA_WIDTH-1:0]     resp_rdata,
  input  logic                      resp_err,
  output logic                      busy,
  output logic                      err_flag,
  output spi_dbg_t                  dbg
);

  // Handshakes: a word moves on a rising edge where valid and ready are both
  // high; the offering side holds valid and payload steady until then.
  spi_state_e state_q, state_d;

  logic                  avs_q;
  logic                  start;
  logic                  rd_q, rd_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  cnt_load;
  logic                  cnt_inc;
  logic                  req_valid_q;
  logic                  req_we_q;
  logic                  wr_ready_q;
  logic                  rd_valid_q;
  logic                  busy_q;

  assign start = (state_q == IDLE) && !cs_sync && address_valid_sync && !avs_q;

  spi_slave_addr_cnt #(
    .ADDR_W (AXI_ADDR_WIDTH),
    .STEP   (addr_step(DATA_WIDTH))
  ) u_addr_cnt (
    .clk_i      (sys_clk),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i (address_sync),
    .inc_i      (cnt_inc),
    .cnt_o      (req_addr)
  );

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_load = 1'b1;
          rd_d     = rd_wr_sync;
          err_d    = 1'b0;
          state_d  = (rd_wr_sync == RW_READ) ? RD_REQ : WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (wr_data_valid) begin
          wdata_d = wr_data;
          state_d = WR_REQ;
        end else if (cs_sync) begin
          state_d = IDLE;
        end
      end
      WR_REQ: begin
        if (req_ready) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (resp_valid) begin
          cnt_inc = 1'b1;
          if (resp_err) err_d = 1'b1;
          state_d = cs_sync ? IDLE : WR_WAIT;
        end
      end
      RD_REQ: begin
        if (req_ready) state_d = RD_RESP;
      end
      RD_RESP: begin
        // A response with chip-select already released is consumed but dropped.
        if (resp_valid) begin
          rdata_d = resp_rdata;
          cnt_inc = 1'b1;
          if (resp_err) err_d = 1'b1;
          state_d = cs_sync ? IDLE : RD_PUSH;
        end
      end
      RD_PUSH: begin
        if (rd_data_ready) begin
          state_d = cs_sync ? IDLE : RD_REQ;
        end else if (cs_sync) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Handshake outputs are decoded from the next state so they are clean flops.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      avs_q       <= 1'b0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      avs_q       <= address_valid_sync;
      req_valid_q <= (state_d == WR_REQ) || (state_d == RD_REQ);
      req_we_q    <= (state_d == WR_REQ);
      wr_ready_q  <= (state_d == WR_WAIT);
      rd_valid_q  <= (state_d == RD_PUSH);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign req_valid     = req_valid_q;
  assign req_we        = req_we_q;
  assign req_wdata     = wdata_q;
  assign wr_data_ready = wr_ready_q;
  assign rd_data       = rdata_q;
  assign rd_data_valid = rd_valid_q;
  assign busy          = busy_q;
  assign err_flag      = err_q;

  always_comb begin
    dbg       = '0;
    dbg.state = state_q;
    dbg.rd    = rd_q;
    dbg.err   = err_q;
  end

endmodule

// File: tb/tb_spi_slave_cmd_ctrl.sv
// Bench for spi_slave_cmd_ctrl: a randomized bus responder plus SPI-side
// drivers, checked against a queue model of the expected request stream.
module tb_spi_slave_cmd_ctrl;
  import spi_slave_pkg::*;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_sync = 1'b1;
  logic [31:0] address_sync = '0;
  logic        address_valid_sync = 1'b0;
  logic        rd_wr_sync = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_data_valid = 1'b0;
  logic        wr_data_ready;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic        rd_data_ready = 1'b0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_rdata = '0;
  logic        resp_err = 1'b0;
  logic        busy;
  logic        err_flag;
  spi_dbg_t    dbg;

  spi_slave_cmd_ctrl #(.AXI_ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .sys_clk(sys_clk), .rst(rst), .cs_sync(cs_sync), .address_sync(address_sync),
    .address_valid_sync(address_valid_sync), .rd_wr_sync(rd_wr_sync),
    .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy), .err_flag(err_flag), .dbg(dbg)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // scoreboard: {we, addr, wdata} of every request the bus should see, in order
  logic [64:0] exp_q[$];
  logic [31:0] resp_data_q[$];
  logic [31:0] rd_src_q[$];
  logic [31:0] wbuf[$];

  int          resp_cd = -1;
  bit          resp_real = 1'b0;
  bit          resp_is_rd = 1'b0;
  int          stall_left = 0;
  bit          spur_en = 1'b0;
  int          req_seen = 0;
  int          err_at = -1;
  int          resp_idx = 0;
  logic [64:0] snap;
  bit          snap_vld = 1'b0;

  // bus responder, acting on the falling edge
  always @(negedge sys_clk) begin
    logic [64:0] e;
    logic [31:0] w;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_real  = 1'b0;
    if (rst) begin
      req_ready = 1'b0;
      resp_cd   = -1;
      snap_vld  = 1'b0;
    end else begin
      if (snap_vld) begin
        check_eq("req_hold_valid", req_valid, 1);
        check_eq("req_hold_payload", {req_we, req_addr, req_wdata}, snap);
      end
      snap_vld  = 1'b0;
      req_ready = 1'b0;
      if (resp_cd == 0) begin
        w = $urandom;
        if (resp_is_rd && rd_src_q.size() > 0) w = rd_src_q.pop_front();
        resp_valid = 1'b1;
        resp_real  = 1'b1;
        resp_rdata = w;
        resp_err   = (resp_idx == err_at);
        if (resp_is_rd) resp_data_q.push_back(w);
        resp_idx++;
        resp_cd = -1;
      end else if (resp_cd > 0) begin
        resp_cd--;
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        resp_rdata = $urandom;
      end
      if (req_valid) begin
        if (stall_left > 0 || $urandom_range(0, 2) == 0) begin
          if (stall_left > 0) stall_left--;
          snap     = {req_we, req_addr, req_wdata};
          snap_vld = 1'b1;
        end else begin
          req_ready = 1'b1;
          req_seen++;
          if (exp_q.size() == 0) begin
            check_eq("req_unexpected", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check_eq("req_we", req_we, e[64]);
            check_eq("req_addr", req_addr, e[63:32]);
            if (e[64]) check_eq("req_wdata", req_wdata, e[31:0]);
          end
          resp_cd    = $urandom_range(0, 2);
          resp_is_rd = !req_we;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic check_zero();
    check_eq("z_req_valid", req_valid, 0);
    check_eq("z_req_we", req_we, 0);
    check_eq("z_req_addr", req_addr, 0);
    check_eq("z_req_wdata", req_wdata, 0);
    check_eq("z_rd_data", rd_data, 0);
    check_eq("z_rd_valid", rd_data_valid, 0);
    check_eq("z_wr_ready", wr_data_ready, 0);
    check_eq("z_busy", busy, 0);
    check_eq("z_err", err_flag, 0);
    check_eq("z_state", dbg.state, IDLE);
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while (busy && cyc < 200) begin
      tick();
      cyc++;
    end
    check_eq(tag, busy, 0);
    check_eq({tag, "_state"}, dbg.state, IDLE);
  endtask

  task automatic wr_burst(input logic [31:0] addr, input int n);
    logic [31:0] w[$];
    logic [31:0] v;
    int k, cyc;
    bit vprev, rprev;
    for (int i = 0; i < n; i++) begin
      v = $urandom;
      if (wbuf.size() > 0) v = wbuf.pop_front();
      w.push_back(v);
      exp_q.push_back({1'b1, addr + 32'(4 * i), v});
    end
    resp_idx = 0;
    address_sync = addr; rd_wr_sync = 1'b0; cs_sync = 1'b0; address_valid_sync = 1'b1;
    tick();
    check_eq("err_clr", err_flag, 0);
    check_eq("wr_start_ready", wr_data_ready, 1);
    k = 0; cyc = 0; rprev = wr_data_ready;
    while (k < n && cyc < 300) begin
      wr_data       = w[k];
      wr_data_valid = ($urandom_range(0, 3) != 0);
      vprev         = wr_data_valid;
      tick();
      cyc++;
      if (vprev && rprev) begin
        check_eq("wr_lat", req_valid, 1);
        k++;
      end
      rprev = wr_data_ready;
    end
    wr_data_valid = 1'b0;
    check_eq("wr_words", k, n);
    cs_sync = 1'b1; address_valid_sync = 1'b0;
    wait_idle("wr_idle");
    check_eq("wr_all_issued", exp_q.size(), 0);
    check_eq("wr_err", err_flag, (err_at >= 0 && err_at < n));
  endtask

  task automatic rd_burst(input logic [31:0] addr, input int n, input int push_stall);
    int got, cyc, stall;
    bit vprev, held, rdy_prev, saw;
    logic [31:0] hv, e;
    for (int i = 0; i <= n; i++) exp_q.push_back({1'b0, addr + 32'(4 * i), 32'h0});
    resp_data_q.delete();
    resp_idx = 0; req_seen = 0;
    address_sync = addr; rd_wr_sync = 1'b1; cs_sync = 1'b0; address_valid_sync = 1'b1;
    rd_data_ready = 1'b0;
    tick();
    check_eq("err_clr", err_flag, 0);
    check_eq("rd_start_lat", req_valid, 1);
    got = 0; cyc = 0; vprev = 1'b0; held = 1'b0; stall = push_stall; hv = '0;
    while (got < n && cyc < 400) begin
      tick();
      cyc++;
      rdy_prev = rd_data_ready;
      rd_data_ready = 1'b0;
      if (rdy_prev && vprev) begin
        got++;
        held = 1'b0;
      end else if (vprev) begin
        check_eq("rd_valid_hold", rd_data_valid, 1);
      end
      if (resp_valid && resp_real && resp_is_rd && resp_idx <= n)
        check_eq("rd_resp_lat", rd_data_valid, 1);
      if (got < n && rd_data_valid) begin
        if (!held) begin
          if (resp_data_q.size() == 0) check_eq("rd_unexpected", resp_data_q.size(), 1);
          else begin
            e = resp_data_q.pop_front();
            check_eq("rd_data", rd_data, e);
          end
          hv = rd_data;
          held = 1'b1;
        end else begin
          check_eq("rd_hold", rd_data, hv);
        end
        if (stall > 0) stall--;
        else rd_data_ready = ($urandom_range(0, 1) != 0);
      end
      vprev = rd_data_valid;
    end
    rd_data_ready = 1'b0;
    check_eq("rd_words", got, n);
    cyc = 0;
    while (req_seen < n + 1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check_eq("rd_ahead", req_seen, n + 1);
    cs_sync = 1'b1; address_valid_sync = 1'b0;
    saw = 1'b0; cyc = 0;
    do begin
      tick();
      cyc++;
      if (rd_data_valid) saw = 1'b1;
    end while (busy && cyc < 100);
    check_eq("rd_drop_no_valid", saw, 0);
    wait_idle("rd_idle");
    check_eq("rd_dropped_word", resp_data_q.size(), 1);
    check_eq("rd_all_issued", exp_q.size(), 0);
    check_eq("rd_err", err_flag, (err_at >= 0 && err_at <= n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int n;
    repeat (3) tick();
    check_zero();
    rst = 1'b0;
    tick();

    wbuf.push_back(32'hDEADBEEF);
    wr_burst(32'h0000_1000, 1);

    rd_src_q = '{32'hA, 32'hB, 32'hC};
    rd_burst(32'h0000_2000, 3, 0);

    stall_left = 5;
    rd_burst(32'h0000_3000, 2, 4);

    wr_burst(32'hFFFF_FFFC, 2);

    err_at = 1;
    wr_burst(32'h0000_4000, 3);
    repeat (3) tick();
    check_eq("err_sticky", err_flag, 1);
    err_at = -1;
    rd_burst(32'h0000_4800, 1, 0);

    // reset while a write request is stalled on the bus
    stall_left = 20;
    exp_q.push_back({1'b1, 32'h0000_5000, 32'h1234_5678});
    address_sync = 32'h0000_5000; rd_wr_sync = 1'b0; cs_sync = 1'b0; address_valid_sync = 1'b1;
    tick();
    wr_data = 32'h1234_5678; wr_data_valid = 1'b1;
    tick();
    wr_data_valid = 1'b0;
    check_eq("rm_req_valid", req_valid, 1);
    check_eq("rm_req_addr", req_addr, 32'h0000_5000);
    check_eq("rm_req_wdata", req_wdata, 32'h1234_5678);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_zero();
    rst = 1'b0; cs_sync = 1'b1; address_valid_sync = 1'b0;
    exp_q.delete(); resp_data_q.delete(); stall_left = 0;
    tick();

    spur_en = 1'b1;
    for (int t = 0; t < 12; t++) begin
      a = $urandom;
      a[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0;
      n = $urandom_range(1, 4);
      err_at = int'($urandom_range(0, 4)) - 1;
      if ($urandom_range(0, 1) != 0) rd_burst(a, n, $urandom_range(0, 2));
      else wr_burst(a, n);
      repeat ($urandom_range(1, 3)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_cmd_ctrl.md
Name: spi_slave_cmd_ctrl

Overview:
- System-clock-side command controller directly downstream of the SPI-to-sys_clk synchronizer.
- Consumes the synchronized chip-select, address, address-valid and read/write flag, and turns each SPI transfer into a sequence of single-word bus requests with auto-incrementing address.
- Moves write words from the RX word stream to the bus and read words from the bus to the TX word stream.
- Sits between the synchronizer and the AXI master plug.

Parameters:
- AXI_ADDR_WIDTH, 32, width of address_sync and req_addr.
- DATA_WIDTH, 32, word width; must be a power of two, at least 8. Address increment per word is DATA_WIDTH/8.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cs_sync  in  1  synchronized SPI chip-select, active low.
- address_sync  in  AXI_ADDR_WIDTH  start address; stable while address_valid_sync is high.
- address_valid_sync  in  1  level; high once the SPI address phase completes.
- rd_wr_sync  in  1  1 = read, 0 = write; valid with address_valid_sync.
- wr_data  in  DATA_WIDTH  RX word from the SPI side.
- wr_data_valid  in  1  RX word available.
- wr_data_ready  out  1  RX word consumed this cycle.
- rd_data  out  DATA_WIDTH  TX word to the SPI side.
- rd_data_valid  out  1  TX word offered.
- rd_data_ready  in  1  TX side accepts the word.
- req_valid  out  1  bus request valid.
- req_ready  in  1  bus accepts the request.
- req_we  out  1  1 = write request.
- req_addr  out  AXI_ADDR_WIDTH  request address.
- req_wdata  out  DATA_WIDTH  write data.
- resp_valid  in  1  bus response; always accepted, no backpressure.
- resp_rdata  in  DATA_WIDTH  read data.
- resp_err  in  1  error flag on the response.
- busy  out  1  high whenever the FSM is not in IDLE.
- err_flag  out  1  sticky error flag for the current transfer.

Behaviour:
- Reset: FSM to IDLE, address counter 0, valid edge register 0, all outputs 0 (req_addr, req_wdata and rd_data included).
- Start condition: a rising edge of address_valid_sync (registered previous value 0, current value 1) while in IDLE with cs_sync == 0.
  - On start: capture address_sync into the counter, latch rd_wr_sync, clear err_flag.
  - Next state is RD_REQ if the latched flag is read, WR_WAIT if write.
  - Edges seen outside IDLE are ignored. The edge register updates every cycle regardless of state.
- FSM states:
  - IDLE.
  - WR_WAIT: wr_data_ready = 1. When wr_data_valid is high, latch wr_data into req_wdata and go to WR_REQ in the same cycle. If cs_sync == 1 and wr_data_valid == 0, go to IDLE.
  - WR_REQ: req_valid = 1, req_we = 1. On req_ready, go to WR_RESP.
  - WR_RESP: on resp_valid, increment the counter. Go to WR_WAIT if cs_sync == 0, else IDLE.
  - RD_REQ: req_valid = 1, req_we = 0. On req_ready, go to RD_RESP.
  - RD_RESP: on resp_valid, latch resp_rdata into rd_data and increment the counter. Go to RD_PUSH if cs_sync == 0, else IDLE (word dropped).
  - RD_PUSH: rd_data_valid = 1. On rd_data_ready, go to RD_REQ if cs_sync == 0, else IDLE. If cs_sync goes to 1 before ready arrives, go to IDLE and drop the word.
- Read-ahead: the next read is issued right after the previous word is handed off, so at most one word is held in the block.
- req_valid, req_we, req_addr and req_wdata are registered. They must stay stable while req_valid is high and req_ready is low. A request is never withdrawn, even if cs_sync rises.
- A response is expected only in *_RESP states. A resp_valid arriving in any other state is ignored.
- Address counter: adds DATA_WIDTH/8 modulo 2^AXI_ADDR_WIDTH; 0xFFFFFFFC + 4 wraps to 0x00000000.
- err_flag: set on any resp_valid with resp_err high; the word still advances. Cleared only at the next start condition or by rst.
- Latency:
  - Start edge to first req_valid on a read: 1 cycle.
  - Write data accepted to req_valid: 1 cycle.
  - Read response to rd_data_valid: 1 cycle.
- Reset asserted mid-transaction: return to IDLE on the next clock edge and drop any in-flight request. The bus side is reset together with this block.

Decomposition:
- Package spi_slave_pkg:
  - FSM state enum: IDLE, WR_WAIT, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RD_PUSH.
  - Read/write encoding constants.
- Optional sub-module spi_slave_addr_cnt: loadable counter with wrapping increment, parameterized by AXI_ADDR_WIDTH and step.

Test Plan:
- Single write: cs_sync = 0, address 0x1000, rd_wr = 0, one word 0xDEADBEEF, req_ready and resp_valid 1 cycle later, then cs_sync = 1 -> one request with req_we = 1, req_addr 0x1000, req_wdata 0xDEADBEEF; FSM returns to IDLE, busy = 0.
- Read burst of 3: address 0x2000, rd_wr = 1, resp_rdata 0xA, 0xB, 0xC, cs_sync held low -> req_addr 0x2000, 0x2004, 0x2008; rd_data 0xA, 0xB, 0xC pushed in order; a 4th read is issued to 0x200C.
- Backpressure: req_ready held low 5 cycles, then rd_data_ready held low 4 cycles -> req_* and rd_data stable throughout; no duplicate requests.
- cs_sync rises during RD_RESP -> response consumed, rd_data_valid never asserted, state IDLE.
- Wrap-around: start address 0xFFFFFFFC, two writes -> req_addr 0xFFFFFFFC, then 0x00000000.
- Error and reset: resp_err = 1 on the 2nd word -> err_flag = 1 until the next start edge. Then assert rst during WR_REQ -> next cycle all outputs 0, state IDLE.
